vec_exec_unit: RTL and testbench
================================

Name: vec_exec_unit

Overview:
- Parametrised successor to the fixed 6-lane x 8-bit vector execute datapath.
- Executes one vector ALU operation over LANES lanes of LANE_W bits using PHYS physical lane ALUs, time-multiplexed over BEATS = LANES/PHYS cycles.
- Adds a valid/ready handshake on both sides, per-lane write mask, optional signed saturation and an overflow flag.
- Sits between the ID/EX operand register and the post-ALU result mux.

Parameters:
LANES, 6, number of logical vector lanes
LANE_W, 8, bits per lane
PHYS, 2, physical lane ALUs; LANES % PHYS must be 0 (elaboration-time assertion)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request
op  input  2  00 ADD, 01 SUB, 10 AND, 11 OR
bcast  input  1  replicate src_b lane 0 to every lane
swap  input  1  exchange operands (SUB computes B-A)
zero_a  input  1  force operand A of lanes 1..LANES-1 to 0
sat  input  1  signed saturation on ADD/SUB
mask  input  LANES  1 = lane written; 0 = lane passes src_a through
src_a  input  LANES*LANE_W  operand A, lane i at bits [i*LANE_W +: LANE_W]
src_b  input  LANES*LANE_W  operand B, same packing
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  LANES*LANE_W  lane results
zero  output  1  all unmasked lane results equal 0
negative  output  1  MSB of lane 0 result if mask[0], else 0
overflow  output  1  signed overflow in any unmasked lane (ADD/SUB only)

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - State goes to IDLE.
  - result, zero, negative, overflow and out_valid go to 0; in_ready goes to 1 once rst deasserts.
- FSM states IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid=1, capture all operand, control and mask inputs into internal registers, set beat=0, clear the flag accumulators, go to BUSY.
  - BUSY: in_ready=0. Each cycle, compute lanes beat*PHYS .. beat*PHYS+PHYS-1, write them into the result register and merge their flags. beat increments; after beat = BEATS-1 go to DONE.
  - DONE: out_valid=1 and result/flags are held stable. On out_ready=1, go to IDLE. A request cannot be accepted in the same cycle the result is released.
- Latency: out_valid rises exactly BEATS cycles after the accepting edge. Throughput is one operation per BEATS+2 cycles.
- Inputs are ignored outside IDLE. Captured operands are immune to later input changes.
- Lane operands:
  - B_i = bcast ? src_b lane 0 : src_b lane i.
  - A_i = (zero_a && i!=0) ? 0 : src_a lane i.
  - If swap is set, A and B are exchanged before the ALU.
- Arithmetic:
  - Two's-complement, modulo 2^LANE_W; carry into each lane is 0.
  - Signed overflow: ADD, operand signs equal and result sign differs. SUB, operand signs differ and result sign differs from the minuend.
  - sat=1 with overflow clamps the lane to 0x7F.. (positive) or 0x80.. (negative). overflow is reported regardless of sat.
  - AND/OR never overflow.
- Masked lanes (mask[i]=0): result lane = A_i before any swap; the lane is excluded from zero and overflow.
- mask all 0: zero=1, negative=0, overflow=0.
- Flags are final only in DONE. Inside BUSY they are partial and not observable as valid.

Decomposition:
- Package vec_pkg: op enum (VOP_ADD, VOP_SUB, VOP_AND, VOP_OR), FSM state enum, default LANES/LANE_W constants, and a function that returns the saturation limits for a given width.
- Sub-module vec_lane_alu (combinational, parameter LANE_W):
  - Inputs: a, b, op, sat.
  - Outputs: y, zero, neg, ovf.
  - Instantiated PHYS times, fed by beat-indexed operand muxes.

Test Plan:
1. ADD, src_a lanes 01..06, src_b all 10, mask 3F -> result lanes 11..16; out_valid exactly 3 cycles after accept; zero=0, overflow=0.
2. SUB, swap=1, bcast=1, src_a all 05, src_b lane0=03, mask 3F -> every lane FE; negative=1, zero=0, overflow=0.
3. ADD, lane0 7F+01, mask 01: with sat=0 -> lane0=80, overflow=1; repeat with sat=1 -> lane0=7F, overflow=1.
4. SUB, mask 01, src_a lane0=05, src_b lane0=05, other lanes A=AA -> lane0=00, lanes 1..5=AA; zero=1, negative=0.
5. Back-pressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> result stable, in_ready=0, no capture. Raise out_ready -> IDLE next cycle, then the new request is accepted.
6. Assert rst during beat 1 of BUSY -> out_valid, result and flags go to 0 immediately. After release in_ready=1, and a fresh ADD completes correctly.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared types and constants for the vector execute unit.
//   vop_e     : lane ALU operation encoding (matches the 2-bit op port)
//   state_e   : control FSM states
//   sat_limits: signed saturation limits for a lane width up to MAX_W bits
package vec_pkg;

    localparam int unsigned DEF_LANES  = 6;
    localparam int unsigned DEF_LANE_W = 8;
    localparam int unsigned MAX_W      = 64;

    typedef enum logic [1:0] {
        VOP_ADD = 2'b00,
        VOP_SUB = 2'b01,
        VOP_AND = 2'b10,
        VOP_OR  = 2'b11
    } vop_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [MAX_W-1:0] pos;
        logic [MAX_W-1:0] neg;
    } sat_lim_t;

    // pos = 0111..1, neg = 1000..0 in the low w bits; upper bits are zero.
    function automatic sat_lim_t sat_limits(int unsigned w);
        sat_lim_t lim;
        lim.pos = '0;
        lim.neg = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i + 1 < w) begin
                lim.pos[i] = 1'b1;
            end else if (i + 1 == w) begin
                lim.neg[i] = 1'b1;
            end
        end
        return lim;
    endfunction

endpackage

// File: rtl/vec_exec_unit_if.sv
// Request/response bundle of the vector execute unit.
//   master: requester/consumer side (drives operands, in_valid, out_ready)
//   slave : execute unit side (drives in_ready, out_valid, result, flags)
interface vec_exec_unit_if #(
    parameter int unsigned LANES  = vec_pkg::DEF_LANES,
    parameter int unsigned LANE_W = vec_pkg::DEF_LANE_W
);
    logic                      in_valid;
    logic                      in_ready;
    logic [1:0]                op;
    logic                      bcast;
    logic                      swap;
    logic                      zero_a;
    logic                      sat;
    logic [LANES-1:0]          mask;
    logic [LANES*LANE_W-1:0]   src_a;
    logic [LANES*LANE_W-1:0]   src_b;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*LANE_W-1:0]   result;
    logic                      zero;
    logic                      negative;
    logic                      overflow;

    modport master (
        output in_valid, op, bcast, swap, zero_a, sat, mask, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, negative, overflow
    );

    modport slave (
        input  in_valid, op, bcast, swap, zero_a, sat, mask, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, negative, overflow
    );
endinterface

// File: rtl/vec_lane_alu.sv
// Combinational single-lane ALU.
//   a, b : lane operands (a is the minuend for SUB)
//   op   : ADD / SUB / AND / OR
//   sat  : clamp signed ADD/SUB overflow to the signed max/min
//   y    : lane result; zero/neg describe y; ovf is signed overflow (ADD/SUB)
module vec_lane_alu import vec_pkg::*; #(
    parameter int unsigned LANE_W = DEF_LANE_W
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  vop_e              op,
    input  logic              sat,
    output logic [LANE_W-1:0] y,
    output logic              zero,
    output logic              neg,
    output logic              ovf
);
    localparam int unsigned MSB = LANE_W - 1;
    localparam sat_lim_t    LIM = sat_limits(LANE_W);

    logic [LANE_W-1:0] sum;
    logic [LANE_W-1:0] diff;

    always_comb begin
        sum  = a + b;
        diff = a - b;
        y    = '0;
        ovf  = 1'b0;
        case (op)
            VOP_ADD: begin
                y   = sum;
                ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            VOP_SUB: begin
                y   = diff;
                ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            VOP_AND: y = a & b;
            VOP_OR:  y = a | b;
            default: y = '0;
        endcase
        // On overflow the sign of a gives the true direction for both ADD and SUB.
        if (sat && ovf) begin
            y = a[MSB] ? LIM.neg[LANE_W-1:0] : LIM.pos[LANE_W-1:0];
        end
        zero = (y == '0);
        neg  = y[MSB];
    end
endmodule

// File: rtl/vec_exec_unit.sv
// Vector execute unit: one ALU operation over LANES lanes of LANE_W bits,
// computed PHYS lanes per cycle over LANES/PHYS beats.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of vec_exec_unit_if (request, operands, mask,
//              result, zero/negative/overflow flags, valid/ready both ways)
module vec_exec_unit import vec_pkg::*; #(
    parameter int unsigned LANES  = DEF_LANES,
    parameter int unsigned LANE_W = DEF_LANE_W,
    parameter int unsigned PHYS   = 2
) (
    input  logic          clk,
    input  logic          rst,
    vec_exec_unit_if.slave bus
);
    localparam int unsigned BEATS = LANES / PHYS;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;

    if (LANES % PHYS != 0) begin : g_lanes_chk
        $error("vec_exec_unit: LANES must be a multiple of PHYS");
    end

    state_e            state;
    logic [BW-1:0]     beat;
    vop_e              op_r;
    logic              sat_r;
    logic              swap_r;
    logic [LANES-1:0]  mask_r;
    // a_r holds A after zero_a, b_r holds B after bcast; swap is applied at the ALU.
    logic [LANE_W-1:0] a_r   [LANES];
    logic [LANE_W-1:0] b_r   [LANES];
    logic [LANE_W-1:0] res_r [LANES];
    logic              zero_r, neg_r, ovf_r;
    logic              in_ready_r, out_valid_r;

    logic [LW-1:0]          idx [PHYS];
    logic [PHYS*LANE_W-1:0] alu_a, alu_b, alu_y;
    logic [PHYS-1:0]        alu_z, alu_n, alu_o;
    logic [PHYS-1:0]        beat_mask, lane0_sel;
    logic                   beat_zero, beat_ovf;

    always_comb begin
        idx       = '{default: '0};
        alu_a     = '0;
        alu_b     = '0;
        beat_mask = '0;
        lane0_sel = '0;
        for (int unsigned p = 0; p < PHYS; p++) begin
            idx[p] = LW'(32'(beat) * PHYS + p);
            alu_a[p*LANE_W +: LANE_W] = swap_r ? b_r[idx[p]] : a_r[idx[p]];
            alu_b[p*LANE_W +: LANE_W] = swap_r ? a_r[idx[p]] : b_r[idx[p]];
            beat_mask[p] = mask_r[idx[p]];
            lane0_sel[p] = (idx[p] == '0) && mask_r[0];
        end
        beat_zero = &(alu_z | ~beat_mask);
        beat_ovf  = |(alu_o & beat_mask);
    end

    for (genvar p = 0; p < PHYS; p++) begin : g_alu
        vec_lane_alu #(.LANE_W(LANE_W)) u_alu (
            .a    (alu_a[p*LANE_W +: LANE_W]),
            .b    (alu_b[p*LANE_W +: LANE_W]),
            .op   (op_r),
            .sat  (sat_r),
            .y    (alu_y[p*LANE_W +: LANE_W]),
            .zero (alu_z[p]),
            .neg  (alu_n[p]),
            .ovf  (alu_o[p])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            beat        <= '0;
            op_r        <= VOP_ADD;
            sat_r       <= 1'b0;
            swap_r      <= 1'b0;
            mask_r      <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                a_r[i]   <= '0;
                b_r[i]   <= '0;
                res_r[i] <= '0;
            end
            zero_r      <= 1'b0;
            neg_r       <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op_r   <= vop_e'(bus.op);
                        sat_r  <= bus.sat;
                        swap_r <= bus.swap;
                        mask_r <= bus.mask;
                        for (int unsigned i = 0; i < LANES; i++) begin
                            a_r[i] <= (bus.zero_a && i != 0) ? '0 : bus.src_a[i*LANE_W +: LANE_W];
                            b_r[i] <= bus.bcast ? bus.src_b[LANE_W-1:0] : bus.src_b[i*LANE_W +: LANE_W];
                        end
                        beat       <= '0;
                        zero_r     <= 1'b1;
                        neg_r      <= 1'b0;
                        ovf_r      <= 1'b0;
                        in_ready_r <= 1'b0;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    for (int unsigned p = 0; p < PHYS; p++) begin
                        res_r[idx[p]] <= beat_mask[p] ? alu_y[p*LANE_W +: LANE_W] : a_r[idx[p]];
                    end
                    zero_r <= zero_r & beat_zero;
                    ovf_r  <= ovf_r | beat_ovf;
                    if (beat == '0) begin
                        neg_r <= |(alu_n & lane0_sel);
                    end
                    if (beat == BW'(BEATS - 1)) begin
                        out_valid_r <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        beat <= beat + BW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_res
        assign bus.result[i*LANE_W +: LANE_W] = res_r[i];
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.zero      = zero_r;
    assign bus.negative  = neg_r;
    assign bus.overflow  = ovf_r;
endmodule

// File: tb/tb_vec_exec_unit.sv
// Self-checking bench for vec_exec_unit (6 lanes x 8 bits, 2 physical ALUs).
module tb_vec_exec_unit;
    import vec_pkg::*;

    localparam int unsigned N   = 6;
    localparam int unsigned W   = 8;
    localparam int unsigned P   = 2;
    localparam int unsigned LAT = N / P;
    localparam int          SMAX = 2 ** (W - 1) - 1;
    localparam int          SMIN = -(2 ** (W - 1));

    typedef struct packed {
        logic [N*W-1:0] result;
        logic           zero;
        logic           neg;
        logic           ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vec_exec_unit_if #(.LANES(N), .LANE_W(W)) vif ();

    vec_exec_unit #(.LANES(N), .LANE_W(W), .PHYS(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t obs_now();
        return {vif.result, vif.zero, vif.negative, vif.overflow};
    endfunction

    // Independent reference: signed integer arithmetic with range checks.
    function automatic exp_t model(input logic [1:0] op, input logic bc, input logic sw,
                                   input logic za, input logic sa, input logic [N-1:0] m,
                                   input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        exp_t e;
        logic [W-1:0] ai, bi, x, y, r;
        int xs, ys, s;
        bit o;
        e.result = '0;
        e.zero   = 1'b1;
        e.ovf    = 1'b0;
        for (int i = 0; i < N; i++) begin
            ai = (za && i != 0) ? '0 : a[i*W +: W];
            bi = bc ? b[W-1:0] : b[i*W +: W];
            x  = sw ? bi : ai;
            y  = sw ? ai : bi;
            xs = $signed(x);
            ys = $signed(y);
            o  = 1'b0;
            s  = 0;
            r  = '0;
            case (op)
                2'b00: s = xs + ys;
                2'b01: s = xs - ys;
                2'b10: r = x & y;
                default: r = x | y;
            endcase
            if (op[1] == 1'b0) begin
                o = (s > SMAX) || (s < SMIN);
                r = s[W-1:0];
                if (o && sa) r = (s > SMAX) ? W'(SMAX) : W'(SMIN);
            end
            if (m[i]) begin
                e.result[i*W +: W] = r;
                if (r != '0) e.zero = 1'b0;
                if (o) e.ovf = 1'b1;
            end else begin
                e.result[i*W +: W] = ai;
            end
        end
        e.neg = m[0] ? e.result[W-1] : 1'b0;
        return e;
    endfunction

    task automatic send(input logic [1:0] op, input logic bc, input logic sw, input logic za,
                        input logic sa, input logic [N-1:0] m, input logic [N*W-1:0] a,
                        input logic [N*W-1:0] b, input exp_t e, output bit ok);
        int n = 0;
        @(negedge clk);
        vif.op = op; vif.bcast = bc; vif.swap = sw; vif.zero_a = za; vif.sat = sa;
        vif.mask = m; vif.src_a = a; vif.src_b = b; vif.in_valid = 1'b1;
        while (vif.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (vif.in_ready === 1'b1);
        if (ok) sb.push_back(e);
        @(posedge clk);
        #1 vif.in_valid = 1'b0;
    endtask

    // Counts accept-to-out_valid edges; gives up after 20.
    task automatic collect(output int lat, output exp_t obs);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (vif.out_valid !== 1'b1 && lat < 20);
        obs = obs_now();
    endtask

    task automatic pop_exp(output exp_t e);
        e = '0;
        if (sb.size() != 0) e = sb.pop_front();
    endtask

    task automatic release_out();
        @(negedge clk);
        vif.out_ready = 1'b1;
        @(posedge clk);
        #1 vif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++; if (vif.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", vif.out_valid); end
        total++; if (vif.result !== '0) begin bad++; $display("FAIL rst_result got=%h want=0", vif.result); end
        total++; if ({vif.zero, vif.negative, vif.overflow} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {vif.zero, vif.negative, vif.overflow}); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++; if (vif.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", vif.in_ready); end
    endtask

    // Runs one directed operation end to end and checks latency and outputs.
    task automatic run_one(input string name, input logic [1:0] op, input logic bc, input logic sw,
                           input logic za, input logic sa, input logic [N-1:0] m,
                           input logic [N*W-1:0] a, input logic [N*W-1:0] b, input exp_t e);
        bit ok; int lat; exp_t obs, exp_v;
        send(op, bc, sw, za, sa, m, a, b, e, ok);
        total++; if (!ok) begin bad++; $display("FAIL %s_accept got=0 want=1", name); end
        collect(lat, obs);
        pop_exp(exp_v);
        total++; if (lat !== LAT) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, LAT); end
        total++; if (obs !== exp_v) begin bad++; $display("FAIL %s_out got=%h want=%h", name, obs, exp_v); end
        release_out();
    endtask

    task automatic test_add();
        run_one("add", 2'b00, 0, 0, 0, 0, 6'h3F, 48'h060504030201, 48'h101010101010,
                '{result: 48'h161514131211, zero: 0, neg: 0, ovf: 0});
    endtask

    task automatic test_sub_swap_bcast();
        run_one("subsw", 2'b01, 1, 1, 0, 0, 6'h3F, 48'h050505050505, 48'h777777777703,
                '{result: 48'hFEFEFEFEFEFE, zero: 0, neg: 1, ovf: 0});
    endtask

    task automatic test_overflow_sat();
        run_one("ovf", 2'b00, 0, 0, 0, 0, 6'h01, 48'h55443322117F, 48'hFFFFFFFFFF01,
                '{result: 48'h554433221180, zero: 0, neg: 1, ovf: 1});
        run_one("sat", 2'b00, 0, 0, 0, 1, 6'h01, 48'h55443322117F, 48'hFFFFFFFFFF01,
                '{result: 48'h55443322117F, zero: 0, neg: 0, ovf: 1});
    endtask

    task automatic test_mask();
        run_one("mask01", 2'b01, 0, 0, 0, 0, 6'h01, 48'hAAAAAAAAAA05, 48'h010101010105,
                '{result: 48'hAAAAAAAAAA00, zero: 1, neg: 0, ovf: 0});
        run_one("mask00", 2'b01, 0, 0, 0, 0, 6'h00, 48'h808080808080, 48'h010101010101,
                '{result: 48'h808080808080, zero: 1, neg: 0, ovf: 0});
    endtask

    task automatic test_backpressure();
        bit ok; int lat; exp_t obs, e1, e2;
        send(2'b11, 0, 0, 0, 0, 6'h3F, 48'h0F0F0F0F0F0F, 48'hF0000000000F,
             '{result: 48'hFF0F0F0F0F0F, zero: 0, neg: 0, ovf: 0}, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_accept got=0 want=1"); end
        collect(lat, obs);
        pop_exp(e1);
        total++; if (obs !== e1) begin bad++; $display("FAIL bp_first got=%h want=%h", obs, e1); end
        vif.op = 2'b10; vif.bcast = 0; vif.swap = 0; vif.zero_a = 0; vif.sat = 0;
        vif.mask = 6'h3F; vif.src_a = 48'hFFFFFFFFFFFF; vif.src_b = 48'h010204081080;
        vif.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            total++; if (vif.out_valid !== 1'b1 || vif.in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold%0d got=%b%b want=10", k, vif.out_valid, vif.in_ready); end
            total++; if (obs_now() !== e1) begin bad++; $display("FAIL bp_stable%0d got=%h want=%h", k, obs_now(), e1); end
        end
        vif.out_ready = 1'b1;
        @(posedge clk);
        #1 vif.out_ready = 1'b0;
        total++; if (vif.out_valid !== 1'b0 || vif.in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle got=%b%b want=01", vif.out_valid, vif.in_ready); end
        e2 = '{result: 48'h010204081080, zero: 0, neg: 1, ovf: 0};
        sb.push_back(e2);
        @(posedge clk);
        #1 vif.in_valid = 1'b0;
        total++; if (vif.in_ready !== 1'b0) begin bad++; $display("FAIL bp_second_accept got=%b want=0", vif.in_ready); end
        collect(lat, obs);
        pop_exp(e2);
        total++; if (lat !== LAT) begin bad++; $display("FAIL bp_latency got=%0d want=%0d", lat, LAT); end
        total++; if (obs !== e2) begin bad++; $display("FAIL bp_second got=%h want=%h", obs, e2); end
        release_out();
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        vif.op = 2'b00; vif.bcast = 0; vif.swap = 0; vif.zero_a = 0; vif.sat = 0;
        vif.mask = 6'h3F; vif.src_a = 48'h111111111111; vif.src_b = 48'h222222222222;
        vif.in_valid = 1'b1;
        @(posedge clk);
        #1 vif.in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (vif.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", vif.out_valid); end
        total++; if (vif.result !== '0) begin bad++; $display("FAIL midrst_result got=%h want=0", vif.result); end
        total++; if ({vif.zero, vif.negative, vif.overflow} !== 3'b000) begin bad++; $display("FAIL midrst_flags got=%b want=000", {vif.zero, vif.negative, vif.overflow}); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++; if (vif.in_ready !== 1'b1 || vif.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_idle got=%b%b want=10", vif.in_ready, vif.out_valid); end
        run_one("postrst", 2'b00, 0, 0, 1, 0, 6'h3F, 48'h0A0B0C0D0E05, 48'h0101010101FB,
                '{result: 48'h010101010100, zero: 0, neg: 0, ovf: 0});
    endtask

    task automatic test_back_to_back();
        logic [1:0] op; logic bc, sw, za, sa; logic [N-1:0] m; logic [N*W-1:0] a, b;
        for (int k = 0; k < 12; k++) begin
            op = 2'($urandom_range(0, 3));
            bc = 1'($urandom()); sw = 1'($urandom()); za = 1'($urandom()); sa = 1'($urandom());
            m  = N'($urandom());
            a  = {16'($urandom()), $urandom()};
            b  = {16'($urandom()), $urandom()};
            run_one("rand", op, bc, sw, za, sa, m, a, b, model(op, bc, sw, za, sa, m, a, b));
        end
    endtask

    initial begin
        vif.in_valid = 0; vif.op = 0; vif.bcast = 0; vif.swap = 0; vif.zero_a = 0;
        vif.sat = 0; vif.mask = '0; vif.src_a = '0; vif.src_b = '0; vif.out_ready = 0;
        test_reset();
        test_add();
        test_sub_swap_bcast();
        test_overflow_sat();
        test_mask();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
